exe_stage_muldiv: RTL and testbench
===================================

Name: exe_stage_muldiv

Overview:
- Execute stage that consumes the ID/EX pipeline-register fields and produces the registered EX/MEM fields.
- Performs single-cycle ALU operations directly.
- Performs 32-bit unsigned multiply, divide and remainder iteratively over 32 cycles. While an iterative op is in progress it asserts stall, which freezes the PC, IF/ID and ID/EX registers.

Parameters:
- WIDTH, 32, datapath width; the iteration count equals WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous kill of the instruction currently in EXE.
- PC_in  in  32  PC of the instruction in EXE.
- Val1_in  in  32  operand A.
- Val2_in  in  32  operand B.
- Reg2_in  in  32  store data.
- dest_in  in  5  destination register.
- EXE_cmd_in  in  4  operation code.
- MEM_R_en_in  in  1  load enable.
- MEM_W_en_in  in  1  store enable.
- WB_en_in  in  1  writeback enable.
- stall  out  1  combinational; high = hold upstream registers.
- PC  out  32  registered PC passthrough.
- ALU_res  out  32  registered result.
- Reg2  out  32  registered store data.
- dest  out  5  registered destination.
- MEM_R_en  out  1  registered load enable.
- MEM_W_en  out  1  registered store enable.
- WB_en  out  1  registered writeback enable.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FSM to IDLE, iteration counter 0, internal accumulators 0. Reset mid-operation aborts the op with no EX/MEM write.
- EXE_cmd encoding:
  - 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 NOR, 0111 XOR
  - 1000 SLL by Val2[4:0], 1001 SRA, 1010 SRL
  - 1100 MUL (low WIDTH bits of the unsigned product)
  - 1101 DIVU (quotient), 1110 REMU (remainder)
  - 0001, 0011, 1011, 1111 produce ALU_res = 0.
- Arithmetic is modulo 2^WIDTH, with no overflow flag.
- Single-cycle ops: stall=0. On the next edge all outputs load from the inputs, with ALU_res = result. Latency is 1 cycle.
- FSM for MUL/DIVU/REMU:
  - IDLE: if the cmd is iterative and flush=0, drive stall=1. On the next edge latch operands, counter=0, go to BUSY. Outputs load a bubble: MEM_R_en=MEM_W_en=WB_en=0, ALU_res=0.
  - BUSY: stall=1. One shift-add (MUL) or restoring shift-subtract (DIV/REM) iteration per edge, counter+1. The edge at counter==WIDTH-1 goes to DONE. Outputs stay a bubble.
  - DONE: stall=0. The next edge loads the EX/MEM outputs with the result and the held input fields, then returns to IDLE.
  - Timing: stall is high for exactly WIDTH+1 = 33 cycles. The result appears on the 34th edge after the op first sits at the inputs.
- Divide by zero: quotient = all ones (0xFFFFFFFF); remainder = Val1. Still takes the full 33 stall cycles.
- Inputs are held stable by the stall. The FSM uses its latched operands only and ignores input changes during BUSY.
- flush=1:
  - Takes precedence over everything except reset.
  - In any state: return to IDLE, stall=0 in that cycle, and the next edge loads a bubble with all enables 0.
  - Flush on the DONE edge discards the result.
- Back-to-back iterative ops: after DONE→IDLE, a new iterative cmd at the inputs restarts the IDLE→BUSY sequence. Stall rises in the same cycle the new op appears.
- A bubble input (all enables 0, cmd ADD) passes through as a bubble.

Test Plan:
- Reset: hold rst=0 for 2 cycles with random inputs → all outputs 0, stall=0. Release → first ADD 5+7 gives ALU_res=12 one edge later.
- ALU sweep:
  - SUB 3−5 → 0xFFFFFFFE
  - SRA 0x80000000 by 4 → 0xF8000000
  - NOR 0,0 → 0xFFFFFFFF
  - Each result appears 1 cycle after issue, with WB_en/dest passed through.
- MUL 0x0001_0001 × 0x0001_0001 (WB_en=1, dest=9) → stall high for exactly 33 cycles. Bubbles output meanwhile. Then ALU_res=0x0002_0001, dest=9, WB_en=1.
- DIVU 100/7 → quotient 14. REMU 100/7 → remainder 2. DIVU 5/0 → 0xFFFFFFFF. REMU 5/0 → 5. Each has a 33-cycle stall.
- Pulse flush at BUSY counter=10 of a MUL → stall drops that cycle, the next output is a bubble with WB_en=0, and no result ever appears. Pulse rst=0 mid-DIVU → outputs clear immediately, stall=0.
- Back-to-back MUL then ADD → ADD result appears exactly 1 edge after the MUL result, and the ADD is never lost or duplicated.

Source files
------------

// File: rtl/exe_stage_muldiv_if.sv
// ID/EX -> EX/MEM bus for the execute stage, including the flush/stall handshake.
// master drives the ID/EX fields and flush; slave returns stall and the EX/MEM fields.
interface exe_stage_muldiv_if #(parameter int WIDTH = 32);
  logic             flush;
  logic [31:0]      PC_in;
  logic [WIDTH-1:0] Val1_in;
  logic [WIDTH-1:0] Val2_in;
  logic [WIDTH-1:0] Reg2_in;
  logic [4:0]       dest_in;
  logic [3:0]       EXE_cmd_in;
  logic             MEM_R_en_in;
  logic             MEM_W_en_in;
  logic             WB_en_in;

  logic             stall;
  logic [31:0]      PC;
  logic [WIDTH-1:0] ALU_res;
  logic [WIDTH-1:0] Reg2;
  logic [4:0]       dest;
  logic             MEM_R_en;
  logic             MEM_W_en;
  logic             WB_en;

  modport master (
    output flush, PC_in, Val1_in, Val2_in, Reg2_in, dest_in, EXE_cmd_in,
           MEM_R_en_in, MEM_W_en_in, WB_en_in,
    input  stall, PC, ALU_res, Reg2, dest, MEM_R_en, MEM_W_en, WB_en
  );

  modport slave (
    input  flush, PC_in, Val1_in, Val2_in, Reg2_in, dest_in, EXE_cmd_in,
           MEM_R_en_in, MEM_W_en_in, WB_en_in,
    output stall, PC, ALU_res, Reg2, dest, MEM_R_en, MEM_W_en, WB_en
  );
endinterface

// File: rtl/exe_stage_muldiv.sv
// Execute stage: single-cycle ALU plus iterative unsigned MUL/DIVU/REMU that
// stalls the front end while busy. All EX/MEM outputs are registered.
module exe_stage_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  exe_stage_muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [3:0] CMD_ADD  = 4'b0000;
  localparam logic [3:0] CMD_SUB  = 4'b0010;
  localparam logic [3:0] CMD_AND  = 4'b0100;
  localparam logic [3:0] CMD_OR   = 4'b0101;
  localparam logic [3:0] CMD_NOR  = 4'b0110;
  localparam logic [3:0] CMD_XOR  = 4'b0111;
  localparam logic [3:0] CMD_SLL  = 4'b1000;
  localparam logic [3:0] CMD_SRA  = 4'b1001;
  localparam logic [3:0] CMD_SRL  = 4'b1010;
  localparam logic [3:0] CMD_MUL  = 4'b1100;
  localparam logic [3:0] CMD_DIVU = 4'b1101;
  localparam logic [3:0] CMD_REMU = 4'b1110;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;

  logic [31:0]      pc_q, pc_d;
  logic [WIDTH-1:0] alu_res_q, alu_res_d;
  logic [WIDTH-1:0] reg2_q, reg2_d;
  logic [4:0]       dest_q, dest_d;
  logic             mem_r_en_q, mem_r_en_d;
  logic             mem_w_en_q, mem_w_en_d;
  logic             wb_en_q, wb_en_d;

  logic             is_iter;
  logic [CW-1:0]    shamt;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             bubble;

  assign is_iter = (bus.EXE_cmd_in == CMD_MUL) || (bus.EXE_cmd_in == CMD_DIVU) ||
                   (bus.EXE_cmd_in == CMD_REMU);
  assign shamt   = bus.Val2_in[CW-1:0];

  // Restoring division: acc holds the partial remainder, opa shifts the dividend
  // out at the top and the quotient bits in at the bottom.
  assign trial = {acc_q, opa_q[WIDTH-1]};
  assign diff  = trial - {1'b0, opb_q};

  // Reset is folded in so a held reset never asks the front end to stall.
  assign bus.stall = rst && !bus.flush &&
                     ((state_q == BUSY) || ((state_q == IDLE) && is_iter));

  always_comb begin
    alu_res = '0;
    case (bus.EXE_cmd_in)
      CMD_ADD: alu_res = bus.Val1_in + bus.Val2_in;
      CMD_SUB: alu_res = bus.Val1_in - bus.Val2_in;
      CMD_AND: alu_res = bus.Val1_in & bus.Val2_in;
      CMD_OR:  alu_res = bus.Val1_in | bus.Val2_in;
      CMD_NOR: alu_res = ~(bus.Val1_in | bus.Val2_in);
      CMD_XOR: alu_res = bus.Val1_in ^ bus.Val2_in;
      CMD_SLL: alu_res = bus.Val1_in << shamt;
      CMD_SRA: alu_res = $signed(bus.Val1_in) >>> shamt;
      CMD_SRL: alu_res = bus.Val1_in >> shamt;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    acc_d      = acc_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    pc_d       = bus.PC_in;
    alu_res_d  = alu_res;
    reg2_d     = bus.Reg2_in;
    dest_d     = bus.dest_in;
    mem_r_en_d = bus.MEM_R_en_in;
    mem_w_en_d = bus.MEM_W_en_in;
    wb_en_d    = bus.WB_en_in;
    bubble     = 1'b0;

    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      bubble  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_iter) begin
            state_d = BUSY;
            cnt_d   = '0;
            cmd_d   = bus.EXE_cmd_in;
            acc_d   = '0;
            opa_d   = bus.Val1_in;
            opb_d   = bus.Val2_in;
            bubble  = 1'b1;
          end
        end
        BUSY: begin
          bubble = 1'b1;
          cnt_d  = cnt_q + CNT_ONE;
          if (cmd_q == CMD_MUL) begin
            acc_d = acc_q + (opb_q[0] ? opa_q : '0);
            opa_d = opa_q << 1;
            opb_d = opb_q >> 1;
          end else begin
            acc_d = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
            opa_d = {opa_q[WIDTH-2:0], ~diff[WIDTH]};
          end
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
          end
        end
        DONE: begin
          alu_res_d = (cmd_q == CMD_DIVU) ? opa_q : acc_q;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    if (bubble) begin
      pc_d       = '0;
      alu_res_d  = '0;
      reg2_d     = '0;
      dest_d     = '0;
      mem_r_en_d = 1'b0;
      mem_w_en_d = 1'b0;
      wb_en_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      acc_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      pc_q       <= '0;
      alu_res_q  <= '0;
      reg2_q     <= '0;
      dest_q     <= '0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      wb_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      acc_q      <= acc_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      pc_q       <= pc_d;
      alu_res_q  <= alu_res_d;
      reg2_q     <= reg2_d;
      dest_q     <= dest_d;
      mem_r_en_q <= mem_r_en_d;
      mem_w_en_q <= mem_w_en_d;
      wb_en_q    <= wb_en_d;
    end
  end

  assign bus.PC       = pc_q;
  assign bus.ALU_res  = alu_res_q;
  assign bus.Reg2     = reg2_q;
  assign bus.dest     = dest_q;
  assign bus.MEM_R_en = mem_r_en_q;
  assign bus.MEM_W_en = mem_w_en_q;
  assign bus.WB_en    = wb_en_q;

endmodule

// File: tb/tb_exe_stage_muldiv.sv
// Directed bench for exe_stage_muldiv: ALU ops, iterative MUL/DIVU/REMU timing,
// flush and reset aborts, and back-to-back issue after an iterative op.
module tb_exe_stage_muldiv;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  exe_stage_muldiv_if #(.WIDTH(32)) bus ();

  exe_stage_muldiv #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pc_for(input logic [4:0] d);
    return 32'h0000_1000 | {25'h0, d, 2'b00};
  endfunction

  task automatic drive(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input logic wb, input logic mr, input logic mw);
    bus.EXE_cmd_in  = cmd;
    bus.Val1_in     = a;
    bus.Val2_in     = b;
    bus.Reg2_in     = a ^ b;
    bus.dest_in     = d;
    bus.PC_in       = pc_for(d);
    bus.WB_en_in    = wb;
    bus.MEM_R_en_in = mr;
    bus.MEM_W_en_in = mw;
    #1;
  endtask

  task automatic drive_bubble();
    drive(4'b0000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.flush = 1'b0;
    drive(4'($urandom), $urandom, $urandom, 5'($urandom), 1'b1, 1'b1, 1'b1);
    tick();
    drive(4'b1100, $urandom, $urandom, 5'($urandom), 1'b1, 1'b1, 1'b1);
    tick();
    checks++;
    if (bus.ALU_res !== 32'h0 || bus.PC !== 32'h0 || bus.dest !== 5'd0 || bus.Reg2 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: ALU_res=%h PC=%h dest=%0d Reg2=%h, want all 0",
               bus.ALU_res, bus.PC, bus.dest, bus.Reg2);
    end
    checks++;
    if (bus.WB_en !== 1'b0 || bus.MEM_R_en !== 1'b0 || bus.MEM_W_en !== 1'b0 || bus.stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: WB=%b MR=%b MW=%b stall=%b, want 0 0 0 0",
               bus.WB_en, bus.MEM_R_en, bus.MEM_W_en, bus.stall);
    end
    rst = 1'b1;
    drive(4'b0000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_stall: stall=%b want 0", bus.stall);
    end
    tick();
    checks++;
    if (bus.ALU_res !== 32'd12 || bus.dest !== 5'd3 || bus.WB_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_add: ALU_res=%h dest=%0d WB=%b, want 0000000c 3 1",
               bus.ALU_res, bus.dest, bus.WB_en);
    end
    drive_bubble();
  endtask

  task automatic test_alu();
    logic [3:0]  cmds [10] = '{4'b0010, 4'b1001, 4'b0110, 4'b1000, 4'b1010,
                               4'b0100, 4'b0101, 4'b0111, 4'b0000, 4'b0011};
    logic [31:0] va   [10] = '{32'd3, 32'h8000_0000, 32'h0, 32'h1, 32'h8000_0000,
                               32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'd5};
    logic [31:0] vb   [10] = '{32'd5, 32'd4, 32'h0, 32'd31, 32'd4,
                               32'hFF00_FF00, 32'h0F0F_0000, 32'h0F0F_0F0F, 32'h1, 32'd7};
    logic [31:0] vexp [10] = '{32'hFFFF_FFFE, 32'hF800_0000, 32'hFFFF_FFFF, 32'h8000_0000,
                               32'h0800_0000, 32'hF000_F000, 32'hFFFF_F0F0, 32'hF0F0_0F0F,
                               32'h0, 32'h0};
    for (int i = 0; i < 10; i++) begin
      drive(cmds[i], va[i], vb[i], 5'(i + 1), 1'(i % 2), 1'b0, 1'(i == 3));
      tick();
      checks++;
      if (bus.ALU_res !== vexp[i] || bus.dest !== 5'(i + 1) || bus.WB_en !== 1'(i % 2) ||
          bus.MEM_W_en !== 1'(i == 3) || bus.PC !== pc_for(5'(i + 1)) ||
          bus.Reg2 !== (va[i] ^ vb[i])) begin
        errors++;
        $display("[TB] FAIL alu_%0d: cmd=%b ALU_res=%h want %h, dest=%0d WB=%b MW=%b PC=%h",
                 i, cmds[i], bus.ALU_res, vexp[i], bus.dest, bus.WB_en, bus.MEM_W_en, bus.PC);
      end
    end
    drive_bubble();
    tick();
  endtask

  task automatic test_iterative(input string name, input logic [3:0] cmd,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp);
    int n;
    int bad;
    n = 0;
    bad = 0;
    drive(cmd, a, b, 5'd9, 1'b1, 1'b0, 1'b0);
    while (bus.stall === 1'b1 && n < 60) begin
      tick();
      n++;
      if (bus.WB_en !== 1'b0 || bus.ALU_res !== 32'h0 || bus.MEM_R_en !== 1'b0 || bus.MEM_W_en !== 1'b0)
        bad++;
    end
    checks++;
    if (n !== 33) begin
      errors++;
      $display("[TB] FAIL %s_stall_len: stall cycles=%0d want 33", name, n);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL %s_bubble: non-bubble outputs during stall=%0d want 0", name, bad);
    end
    tick();
    checks++;
    if (bus.ALU_res !== exp || bus.dest !== 5'd9 || bus.WB_en !== 1'b1 || bus.PC !== pc_for(5'd9)) begin
      errors++;
      $display("[TB] FAIL %s_result: ALU_res=%h want %h, dest=%0d WB=%b PC=%h",
               name, bus.ALU_res, exp, bus.dest, bus.WB_en, bus.PC);
    end
    drive_bubble();
    tick();
  endtask

  task automatic test_flush();
    int hits;
    hits = 0;
    drive(4'b1100, 32'h0001_0001, 32'h0001_0001, 5'd9, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) tick();
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_pre_stall: stall=%b want 1", bus.stall);
    end
    bus.flush = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_stall_drop: stall=%b want 0", bus.stall);
    end
    drive_bubble();
    tick();
    bus.flush = 1'b0;
    checks++;
    if (bus.WB_en !== 1'b0 || bus.ALU_res !== 32'h0) begin
      errors++;
      $display("[TB] FAIL flush_bubble: WB=%b ALU_res=%h want 0 0", bus.WB_en, bus.ALU_res);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.WB_en !== 1'b0 || bus.ALU_res !== 32'h0 || bus.stall !== 1'b0) hits++;
    end
    checks++;
    if (hits !== 0) begin
      errors++;
      $display("[TB] FAIL flush_no_result: stray cycles=%0d want 0", hits);
    end
  endtask

  task automatic test_reset_mid();
    drive(4'b1101, 32'd100, 32'd7, 5'd5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rstmid_pre_stall: stall=%b want 1", bus.stall);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.ALU_res !== 32'h0 || bus.WB_en !== 1'b0 || bus.dest !== 5'd0) begin
      errors++;
      $display("[TB] FAIL rstmid_clear: stall=%b ALU_res=%h WB=%b dest=%0d want 0",
               bus.stall, bus.ALU_res, bus.WB_en, bus.dest);
    end
    drive_bubble();
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (bus.WB_en !== 1'b0 || bus.stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rstmid_after: WB=%b stall=%b want 0 0", bus.WB_en, bus.stall);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    n = 0;
    drive(4'b1100, 32'd3, 32'd4, 5'd9, 1'b1, 1'b0, 1'b0);
    while (bus.stall === 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 33) begin
      errors++;
      $display("[TB] FAIL b2b_stall_len: stall cycles=%0d want 33", n);
    end
    tick();
    checks++;
    if (bus.ALU_res !== 32'd12 || bus.dest !== 5'd9 || bus.WB_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_mul: ALU_res=%h dest=%0d WB=%b want 0000000c 9 1",
               bus.ALU_res, bus.dest, bus.WB_en);
    end
    drive(4'b0000, 32'd1, 32'd2, 5'd4, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_add_stall: stall=%b want 0", bus.stall);
    end
    tick();
    checks++;
    if (bus.ALU_res !== 32'd3 || bus.dest !== 5'd4 || bus.WB_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_add: ALU_res=%h dest=%0d WB=%b want 00000003 4 1",
               bus.ALU_res, bus.dest, bus.WB_en);
    end
    drive_bubble();
    tick();
    checks++;
    if (bus.WB_en !== 1'b0 || bus.ALU_res !== 32'h0 || bus.dest !== 5'd0) begin
      errors++;
      $display("[TB] FAIL b2b_no_dup: WB=%b ALU_res=%h dest=%0d want 0 0 0",
               bus.WB_en, bus.ALU_res, bus.dest);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    bus.flush = 1'b0;
    drive_bubble();
    test_reset();
    test_alu();
    test_iterative("mul", 4'b1100, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001);
    test_iterative("divu", 4'b1101, 32'd100, 32'd7, 32'd14);
    test_iterative("remu", 4'b1110, 32'd100, 32'd7, 32'd2);
    test_iterative("divu0", 4'b1101, 32'd5, 32'd0, 32'hFFFF_FFFF);
    test_iterative("remu0", 4'b1110, 32'd5, 32'd0, 32'd5);
    test_flush();
    test_reset_mid();
    test_iterative("divu_post_rst", 4'b1101, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF);
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
